hazard_ctrl: RTL

Pipeline hazard and PC-select controller for the 16-bit, five-stage processor: IF, ID, EX, MEM, WB. It tracks destination-register metadata for the EX, MEM and WB stages. From that it drives the select inputs of the two 3-way operand-forwarding muxes and the 3-way 10-bit PC-source mux. It also generates stall and flush for the IF/ID and ID/EX pipeline registers and keeps saturating hazard counters.

---
 rtl/hazard_pkg.sv | 22 ++
 rtl/fwd_sel_unit.sv | 30 +++
 rtl/hazard_ctrl.sv | 100 ++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// Shared encodings and stage-record type for the pipeline hazard controller.
package hazard_pkg;

  localparam int unsigned REG_W = 3;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;

  // {pc_sel1, pc_sel2}
  localparam logic [1:0] PC_SEQ = 2'b01;
  localparam logic [1:0] PC_BR  = 2'b10;
  localparam logic [1:0] PC_JMP = 2'b00;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
    logic             wr_en;
    logic             is_load;
  } stage_rec_t;

endpackage

// File: rtl/fwd_sel_unit.sv
// Per-operand forwarding select: nearest older producer of rs wins, R0 never forwards.
module fwd_sel_unit
  import hazard_pkg::*;
(
  input  logic [REG_W-1:0] rs,
  input  logic             use_rs,
  input  stage_rec_t       ex,
  input  stage_rec_t       mem,
  output logic [1:0]       sel_c
);

  logic ex_hit_c;
  logic mem_hit_c;
  logic unused_load;

  assign ex_hit_c  = ex.valid  && ex.wr_en  && (ex.rd  == rs) && (rs != '0);
  assign mem_hit_c = mem.valid && mem.wr_en && (mem.rd == rs) && (rs != '0);

  // Load latency is handled by the stall logic, not here.
  assign unused_load = ex.is_load ^ mem.is_load;

  always_comb begin
    sel_c = FWD_RF;
    if (use_rs) begin
      if (ex_hit_c)       sel_c = FWD_EXMEM;
      else if (mem_hit_c) sel_c = FWD_MEMWB;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard detection, forwarding-select and PC-source control for the 5-stage pipeline.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned REG_BITS = 3,
  parameter int unsigned CNT_BITS = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                id_valid,
  input  logic [REG_BITS-1:0] id_rs1,
  input  logic [REG_BITS-1:0] id_rs2,
  input  logic                id_use1,
  input  logic                id_use2,
  input  logic [REG_BITS-1:0] id_rd,
  input  logic                id_wr_en,
  input  logic                id_is_load,
  input  logic                id_jump,
  input  logic                ex_branch_taken,
  output logic [1:0]          fwd_a_sel,
  output logic [1:0]          fwd_b_sel,
  output logic                pc_sel1,
  output logic                pc_sel2,
  output logic                stall,
  output logic                flush_if,
  output logic                flush_id,
  output logic [CNT_BITS-1:0] stall_cnt,
  output logic [CNT_BITS-1:0] flush_cnt
);

  stage_rec_t       ex_q, mem_q, wb_q;
  stage_rec_t       id_rec_c;
  logic [REG_W-1:0] rs1_c, rs2_c;
  logic [1:0]       fwd_a_c, fwd_b_c;
  logic [1:0]       pc_c;
  logic             load_use_c;
  logic             bubble_c;
  logic             unused_wb;

  assign rs1_c    = REG_W'(id_rs1);
  assign rs2_c    = REG_W'(id_rs2);
  assign id_rec_c = '{valid: id_valid, rd: REG_W'(id_rd), wr_en: id_wr_en, is_load: id_is_load};

  // WB retires into a write-through register file, so nothing downstream reads it.
  assign unused_wb = ^wb_q;

  fwd_sel_unit u_fwd_a (.rs(rs1_c), .use_rs(id_use1), .ex(ex_q), .mem(mem_q), .sel_c(fwd_a_c));
  fwd_sel_unit u_fwd_b (.rs(rs2_c), .use_rs(id_use2), .ex(ex_q), .mem(mem_q), .sel_c(fwd_b_c));

  assign load_use_c = id_valid && ex_q.valid && ex_q.is_load && ex_q.wr_en && (ex_q.rd != '0) &&
                      ((id_use1 && (rs1_c == ex_q.rd)) || (id_use2 && (rs2_c == ex_q.rd)));

  // Branch > load-use > jump > sequential; reset forces the quiet state.
  always_comb begin
    stall    = 1'b0;
    flush_if = 1'b0;
    flush_id = 1'b0;
    pc_c     = PC_SEQ;
    if (!rst) begin
      if (ex_branch_taken) begin
        pc_c     = PC_BR;
        flush_if = 1'b1;
        flush_id = 1'b1;
      end else if (load_use_c) begin
        stall    = 1'b1;
        flush_id = 1'b1;
      end else if (id_jump && id_valid) begin
        pc_c     = PC_JMP;
        flush_if = 1'b1;
      end
    end
  end

  assign pc_sel1  = pc_c[1];
  assign pc_sel2  = pc_c[0];
  assign bubble_c = stall || flush_id;

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q      <= '0;
      mem_q     <= '0;
      wb_q      <= '0;
      fwd_a_sel <= FWD_RF;
      fwd_b_sel <= FWD_RF;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      ex_q      <= bubble_c ? stage_rec_t'('0) : id_rec_c;
      mem_q     <= ex_q;
      wb_q      <= mem_q;
      fwd_a_sel <= bubble_c ? FWD_RF : fwd_a_c;
      fwd_b_sel <= bubble_c ? FWD_RF : fwd_b_c;
      if (stall && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNT_BITS'(1);
      if ((flush_if || flush_id) && (flush_cnt != '1))
        flush_cnt <= flush_cnt + CNT_BITS'(1);
    end
  end

endmodule
